// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decoded operands/control, inserts bubbles,
// detects load-use hazards and, with ID_EX_FWD_EN defined, forwards EX operands.
module id_ex_reg #(
    parameter int DW  = 16,
    parameter int RW  = 4,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           stall,
    input  logic           flush,
    input  logic           id_valid,
    input  logic [OPW-1:0] id_opcode,
    input  logic [RW-1:0]  id_rs,
    input  logic [RW-1:0]  id_rt,
    input  logic [RW-1:0]  id_rd,
    input  logic [DW-1:0]  id_rs_data,
    input  logic [DW-1:0]  id_rt_data,
    input  logic [DW-1:0]  id_imm,
    input  logic           id_reg_write,
    input  logic           id_mem_read,
    input  logic           id_mem_write,
    input  logic           exm_reg_write,
    input  logic [RW-1:0]  exm_rd,
    input  logic [DW-1:0]  exm_data,
    input  logic           mwb_reg_write,
    input  logic [RW-1:0]  mwb_rd,
    input  logic [DW-1:0]  mwb_data,
    output logic           ex_valid,
    output logic [OPW-1:0] ex_opcode,
    output logic [RW-1:0]  ex_rd,
    output logic [DW-1:0]  ex_a,
    output logic [DW-1:0]  ex_b,
    output logic [DW-1:0]  ex_imm,
    output logic           ex_reg_write,
    output logic           ex_mem_read,
    output logic           ex_mem_write,
    output logic           hz_stall
);

    typedef struct packed {
        logic           valid;
        logic [OPW-1:0] opcode;
        logic [RW-1:0]  rs;
        logic [RW-1:0]  rt;
        logic [RW-1:0]  rd;
        logic [DW-1:0]  rs_data;
        logic [DW-1:0]  rt_data;
        logic [DW-1:0]  imm;
        logic           reg_write;
        logic           mem_read;
        logic           mem_write;
    } ex_stage_t;

    ex_stage_t stage_q, stage_d;

    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = '0;
        end else if (!stall) begin
            stage_d.valid     = id_valid;
            stage_d.opcode    = id_opcode;
            stage_d.rs        = id_rs;
            stage_d.rt        = id_rt;
            stage_d.rd        = id_rd;
            stage_d.rs_data   = id_rs_data;
            stage_d.rt_data   = id_rt_data;
            stage_d.imm       = id_imm;
            // A non-instruction must never write state downstream.
            stage_d.reg_write = id_valid & id_reg_write;
            stage_d.mem_read  = id_valid & id_mem_read;
            stage_d.mem_write = id_valid & id_mem_write;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) stage_q <= '0;
        else     stage_q <= stage_d;
    end

    always_comb begin
        ex_a = (stage_q.rs == '0) ? '0 : stage_q.rs_data;
        ex_b = (stage_q.rt == '0) ? '0 : stage_q.rt_data;
`ifdef ID_EX_FWD_EN
        // Youngest producer (EX/MEM) wins over MEM/WB; R0 is never forwarded.
        if (stage_q.rs != '0) begin
            if (exm_reg_write && exm_rd == stage_q.rs)      ex_a = exm_data;
            else if (mwb_reg_write && mwb_rd == stage_q.rs) ex_a = mwb_data;
        end
        if (stage_q.rt != '0) begin
            if (exm_reg_write && exm_rd == stage_q.rt)      ex_b = exm_data;
            else if (mwb_reg_write && mwb_rd == stage_q.rt) ex_b = mwb_data;
        end
`endif
    end

`ifndef ID_EX_FWD_EN
    logic unused_fwd;
    assign unused_fwd = ^{exm_reg_write, exm_rd, exm_data, mwb_reg_write, mwb_rd, mwb_data};
`endif

    assign ex_valid     = stage_q.valid;
    assign ex_opcode    = stage_q.opcode;
    assign ex_rd        = stage_q.rd;
    assign ex_imm       = stage_q.imm;
    assign ex_reg_write = stage_q.valid & stage_q.reg_write;
    assign ex_mem_read  = stage_q.valid & stage_q.mem_read;
    assign ex_mem_write = stage_q.valid & stage_q.mem_write;

    assign hz_stall = ex_valid & ex_mem_read & id_valid & (stage_q.rd != '0) &
                      ((stage_q.rd == id_rs) | (stage_q.rd == id_rt));

endmodule
